// File: rtl/interp_block_collector_pkg.sv
// rtl/interp_block_collector_pkg.sv - shared constants, index types and block packing
package interp_block_collector_pkg;

  localparam int ROWS     = 4;
  localparam int COLS     = 4;
  localparam int PIX_MAX  = 255;
  localparam int PIX_BITS = 8;
  localparam int BLK_W    = ROWS * COLS * PIX_BITS;

  typedef logic       bank_idx_t;
  typedef logic [1:0] row_idx_t;

  typedef logic [COLS-1:0][PIX_BITS-1:0] row_t;
  typedef row_t [ROWS-1:0]               bank_t;

  // Row 0 lands in the top 32 bits; column 0 is the most significant byte of its row.
  function automatic logic [BLK_W-1:0] pack_block(input bank_t b);
    logic [BLK_W-1:0] r;
    r = '0;
    for (int row = 0; row < ROWS; row++) begin
      for (int c = 0; c < COLS; c++) begin
        r[BLK_W-1-(row*COLS*PIX_BITS + c*PIX_BITS) -: PIX_BITS] = b[row][c];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/interp_block_collector_round_clip_pixel.sv
// rtl/interp_block_collector_round_clip_pixel.sv - signed sample to unsigned pixel: optional round/shift, then clip
module round_clip_pixel
  import interp_block_collector_pkg::*;
#(
  parameter int SHIFT = 6,
  parameter int IN_W  = 14,
  parameter int PIX_W = 8
) (
  input  logic [IN_W-1:0]  x_i,
  input  logic             round_en_i,
  output logic [PIX_W-1:0] pix_o
);

  localparam int HALF_I = 1 << (SHIFT - 1);
  localparam logic signed [IN_W:0] HALF = (IN_W+1)'(HALF_I);
  localparam logic signed [IN_W:0] MAXV = (IN_W+1)'(PIX_MAX);

  logic signed [IN_W:0] x_ext;
  logic signed [IN_W:0] sum;
  logic signed [IN_W:0] y;

  // One extra bit of headroom keeps the rounding add from wrapping at the top of the range.
  always_comb begin
    x_ext = $signed({x_i[IN_W-1], x_i});
    sum   = x_ext + HALF;
    y     = round_en_i ? (sum >>> SHIFT) : x_ext;
    if (y < 0) begin
      pix_o = '0;
    end else if (y > MAXV) begin
      pix_o = PIX_W'(PIX_MAX);
    end else begin
      pix_o = y[PIX_W-1:0];
    end
  end

endmodule

// File: rtl/interp_block_collector.sv
// rtl/interp_block_collector.sv - gathers four converted rows into 4x4 blocks, ping-pong banked
module interp_block_collector
  import interp_block_collector_pkg::*;
#(
  parameter int SHIFT = 6,
  parameter int IN_W  = 14,
  parameter int PIX_W = 8
) (
  input  logic              CLK,
  input  logic              RST_ASYNC_N,
  input  logic              FLUSH,
  input  logic              ROUND_EN,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [IN_W-1:0]   IN_SAMPLE_0,
  input  logic [IN_W-1:0]   IN_SAMPLE_1,
  input  logic [IN_W-1:0]   IN_SAMPLE_2,
  input  logic [IN_W-1:0]   IN_SAMPLE_3,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [BLK_W-1:0]  OUT_BLOCK,
  output logic [7:0]        BLOCK_CNT
);

  logic [1:0] full_q, full_d;
  bank_idx_t  fill_ptr_q, fill_ptr_d;
  bank_idx_t  rd_ptr_q, rd_ptr_d;
  row_idx_t   row_cnt_q, row_cnt_d;
  logic [7:0] blk_cnt_q, blk_cnt_d;
  logic       round_en_q, round_en_d;
  bank_t      bank_q [2];

  logic [IN_W-1:0]             samp [COLS];
  logic [COLS-1:0][PIX_W-1:0]  row_pix;
  logic                        round_sel;
  logic                        accept;
  logic                        deliver;

  assign samp[0] = IN_SAMPLE_0;
  assign samp[1] = IN_SAMPLE_1;
  assign samp[2] = IN_SAMPLE_2;
  assign samp[3] = IN_SAMPLE_3;

  // Row 0 uses the live ROUND_EN; later rows reuse the value captured with row 0.
  assign round_sel = (row_cnt_q == 2'd0) ? ROUND_EN : round_en_q;

  for (genvar c = 0; c < COLS; c++) begin : g_pix
    round_clip_pixel #(
      .SHIFT (SHIFT),
      .IN_W  (IN_W),
      .PIX_W (PIX_W)
    ) u_pix (
      .x_i        (samp[c]),
      .round_en_i (round_sel),
      .pix_o      (row_pix[c])
    );
  end

  assign IN_READY  = !full_q[fill_ptr_q];
  assign OUT_VALID = full_q[rd_ptr_q];
  assign OUT_BLOCK = pack_block(bank_q[rd_ptr_q]);
  assign BLOCK_CNT = blk_cnt_q;

  assign accept  = IN_VALID && IN_READY && !FLUSH;
  assign deliver = OUT_VALID && OUT_READY && !FLUSH;

  always_comb begin
    full_d     = full_q;
    fill_ptr_d = fill_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    row_cnt_d  = row_cnt_q;
    blk_cnt_d  = blk_cnt_q;
    round_en_d = round_en_q;
    if (FLUSH) begin
      full_d     = '0;
      fill_ptr_d = 1'b0;
      rd_ptr_d   = 1'b0;
      row_cnt_d  = '0;
    end else begin
      if (accept) begin
        row_cnt_d = row_cnt_q + 2'd1;
        if (row_cnt_q == 2'd0) begin
          round_en_d = ROUND_EN;
        end
        if (row_cnt_q == row_idx_t'(ROWS - 1)) begin
          full_d[fill_ptr_q] = 1'b1;
          fill_ptr_d         = !fill_ptr_q;
          row_cnt_d          = '0;
        end
      end
      // A full bank never accepts rows, so these two bank updates cannot collide.
      if (deliver) begin
        full_d[rd_ptr_q] = 1'b0;
        rd_ptr_d         = !rd_ptr_q;
        blk_cnt_d        = blk_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      full_q     <= '0;
      fill_ptr_q <= 1'b0;
      rd_ptr_q   <= 1'b0;
      row_cnt_q  <= '0;
      blk_cnt_q  <= '0;
      round_en_q <= 1'b0;
    end else begin
      full_q     <= full_d;
      fill_ptr_q <= fill_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      row_cnt_q  <= row_cnt_d;
      blk_cnt_q  <= blk_cnt_d;
      round_en_q <= round_en_d;
    end
  end

  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      bank_q[0] <= '0;
      bank_q[1] <= '0;
    end else if (accept) begin
      bank_q[fill_ptr_q][row_cnt_q] <= row_pix;
    end
  end

  a_in_stable : assert property (
    @(posedge CLK) disable iff (!RST_ASYNC_N || FLUSH)
    (IN_VALID && !IN_READY) |=>
      (IN_VALID && $stable({IN_SAMPLE_0, IN_SAMPLE_1, IN_SAMPLE_2, IN_SAMPLE_3}))
  );

endmodule

// File: tb/tb_interp_block_collector.sv
// tb/tb_interp_block_collector.sv - scoreboard bench for interp_block_collector
module tb_interp_block_collector;

  localparam int SHIFT = 6;

  logic         CLK;
  logic         RST_ASYNC_N;
  logic         FLUSH;
  logic         ROUND_EN;
  logic         IN_VALID;
  logic         IN_READY;
  logic [13:0]  IN_SAMPLE_0, IN_SAMPLE_1, IN_SAMPLE_2, IN_SAMPLE_3;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [127:0] OUT_BLOCK;
  logic [7:0]   BLOCK_CNT;

  interp_block_collector #(.SHIFT(SHIFT), .IN_W(14), .PIX_W(8)) dut (
    .CLK         (CLK),
    .RST_ASYNC_N (RST_ASYNC_N),
    .FLUSH       (FLUSH),
    .ROUND_EN    (ROUND_EN),
    .IN_VALID    (IN_VALID),
    .IN_READY    (IN_READY),
    .IN_SAMPLE_0 (IN_SAMPLE_0),
    .IN_SAMPLE_1 (IN_SAMPLE_1),
    .IN_SAMPLE_2 (IN_SAMPLE_2),
    .IN_SAMPLE_3 (IN_SAMPLE_3),
    .OUT_VALID   (OUT_VALID),
    .OUT_READY   (OUT_READY),
    .OUT_BLOCK   (OUT_BLOCK),
    .BLOCK_CNT   (BLOCK_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int           checks = 0;
  int           errors = 0;
  logic [127:0] exp_q [$];
  logic [31:0]  part_q [$];
  bit           part_rnd;
  int           exp_cnt = 0;
  bit           mon_en = 0;

  function automatic int ref_pix(input int x, input bit rnd);
    int y;
    int d;
    d = 1 << SHIFT;
    y = x;
    if (rnd) begin
      y = x + d / 2;
      if (y >= 0) y = y / d;
      else        y = -((-y + d - 1) / d);
    end
    if (y < 0)   return 0;
    if (y > 255) return 255;
    return y;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Input monitor: converts every accepted row with the reference rules and queues finished blocks.
  always @(negedge CLK) begin
    if (mon_en && RST_ASYNC_N) begin
      if (FLUSH) begin
        part_q.delete();
        exp_q.delete();
      end else if (IN_VALID && IN_READY) begin
        if (part_q.size() == 0) part_rnd = ROUND_EN;
        part_q.push_back({8'(ref_pix($signed(IN_SAMPLE_0), part_rnd)),
                          8'(ref_pix($signed(IN_SAMPLE_1), part_rnd)),
                          8'(ref_pix($signed(IN_SAMPLE_2), part_rnd)),
                          8'(ref_pix($signed(IN_SAMPLE_3), part_rnd))});
        if (part_q.size() == 4) begin
          exp_q.push_back({part_q[0], part_q[1], part_q[2], part_q[3]});
          part_q.delete();
        end
      end
    end
  end

  // Output monitor: compares each delivered block and the running block count.
  always @(negedge CLK) begin
    if (mon_en && RST_ASYNC_N) begin
      chk("block_cnt", 128'(BLOCK_CNT), 128'(exp_cnt % 256));
      if (!FLUSH && OUT_VALID && OUT_READY) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_block actual=%h expected=none", OUT_BLOCK);
        end else begin
          chk("block_data", OUT_BLOCK, exp_q.pop_front());
        end
        exp_cnt++;
      end
    end
  end

  task automatic send_row(input int s0, input int s1, input int s2, input int s3,
                          input bit rnd, output int stalls);
    IN_SAMPLE_0 = 14'(s0);
    IN_SAMPLE_1 = 14'(s1);
    IN_SAMPLE_2 = 14'(s2);
    IN_SAMPLE_3 = 14'(s3);
    ROUND_EN    = rnd;
    IN_VALID    = 1'b1;
    stalls      = 0;
    @(negedge CLK);
    while (!IN_READY) begin
      stalls++;
      if (stalls > 200) begin
        checks++;
        errors++;
        $display("FAIL send_row_timeout actual=stalled expected=accepted");
        IN_VALID = 1'b0;
        return;
      end
      @(negedge CLK);
    end
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
  endtask

  task automatic send_rand(input bit rnd, output int stalls);
    send_row(int'($urandom_range(0, 16383)) - 8192, int'($urandom_range(0, 16383)) - 8192,
             int'($urandom_range(0, 16383)) - 8192, int'($urandom_range(0, 16383)) - 8192,
             rnd, stalls);
  endtask

  task automatic wait_drain();
    int n;
    OUT_READY = 1'b1;
    n = 0;
    @(negedge CLK);
    while (exp_q.size() != 0 || OUT_VALID) begin
      n++;
      if (n > 100) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout actual=%0d_pending expected=0", exp_q.size());
        break;
      end
      @(negedge CLK);
    end
    @(posedge CLK);
    #1;
    OUT_READY = 1'b0;
  endtask

  initial begin
    int st;
    int tot;
    int base;
    bit done;
    RST_ASYNC_N = 1'b0;
    FLUSH = 1'b0;
    ROUND_EN = 1'b0;
    IN_VALID = 1'b0;
    OUT_READY = 1'b0;
    IN_SAMPLE_0 = '0; IN_SAMPLE_1 = '0; IN_SAMPLE_2 = '0; IN_SAMPLE_3 = '0;
    repeat (2) @(posedge CLK);
    #1;
    RST_ASYNC_N = 1'b1;
    mon_en = 1;

    @(negedge CLK);
    chk("rst_out_valid", 128'(OUT_VALID), 128'(0));
    chk("rst_in_ready", 128'(IN_READY), 128'(1));
    chk("rst_block_cnt", 128'(BLOCK_CNT), 128'(0));
    chk("rst_out_block", OUT_BLOCK, 128'(0));
    @(posedge CLK);
    #1;

    // Rounding: 64,95,96,-32 -> 1,1,2,0
    send_row(64, 95, 96, -32, 1'b1, st);
    @(negedge CLK);
    chk("first_row_visible", 128'(OUT_BLOCK[127:96]), 128'(32'h01010200));
    chk("partial_not_valid", 128'(OUT_VALID), 128'(0));
    @(posedge CLK);
    #1;
    for (int r = 1; r < 4; r++) send_row(64, 95, 96, -32, 1'b1, st);
    @(negedge CLK);
    chk("round_valid_latency", 128'(OUT_VALID), 128'(1));
    chk("round_block", OUT_BLOCK, {4{32'h01010200}});
    @(posedge CLK);
    #1;
    OUT_READY = 1'b1;
    @(posedge CLK);
    #1;
    OUT_READY = 1'b0;
    @(negedge CLK);
    chk("round_block_cnt", 128'(BLOCK_CNT), 128'(1));
    @(posedge CLK);
    #1;

    // Clip only
    for (int r = 0; r < 3; r++) send_row(300, -5, 255, 0, 1'b0, st);
    send_row(8191, -8192, 256, 1, 1'b0, st);
    @(negedge CLK);
    chk("clip_block", OUT_BLOCK, {32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF01});
    @(posedge CLK);
    #1;
    wait_drain();

    // Backpressure: both banks fill, row 9 stalls until one block leaves
    tot = 0;
    for (int r = 0; r < 8; r++) begin
      send_rand(1'($urandom_range(0, 1)), st);
      tot += st;
    end
    chk("bp_first8_stalls", 128'(tot), 128'(0));
    IN_SAMPLE_0 = 14'($urandom); IN_SAMPLE_1 = 14'($urandom);
    IN_SAMPLE_2 = 14'($urandom); IN_SAMPLE_3 = 14'($urandom);
    IN_VALID = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk("bp_in_ready_low", 128'(IN_READY), 128'(0));
    end
    @(posedge CLK);
    #1;
    OUT_READY = 1'b1;
    @(posedge CLK);
    #1;
    OUT_READY = 1'b0;
    @(negedge CLK);
    chk("bp_in_ready_back", 128'(IN_READY), 128'(1));
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    tot = 0;
    for (int r = 0; r < 3; r++) begin
      send_rand(1'b1, st);
      tot += st;
    end
    chk("bp_rows10_12_stalls", 128'(tot), 128'(0));
    wait_drain();

    // Streaming: 8 blocks back to back
    base = exp_cnt;
    OUT_READY = 1'b1;
    tot = 0;
    for (int r = 0; r < 32; r++) begin
      send_rand(1'($urandom_range(0, 1)), st);
      tot += st;
    end
    chk("stream_stalls", 128'(tot), 128'(0));
    wait_drain();
    @(negedge CLK);
    chk("stream_block_cnt", 128'(BLOCK_CNT), 128'((base + 8) % 256));
    @(posedge CLK);
    #1;

    // Flush with a full block pending and two rows in flight
    for (int r = 0; r < 6; r++) send_rand(1'b1, st);
    FLUSH = 1'b1;
    @(posedge CLK);
    #1;
    FLUSH = 1'b0;
    @(negedge CLK);
    chk("flush_out_valid", 128'(OUT_VALID), 128'(0));
    chk("flush_in_ready", 128'(IN_READY), 128'(1));
    @(posedge CLK);
    #1;
    for (int r = 0; r < 4; r++)
      send_row((r*4+1)*64, (r*4+2)*64, (r*4+3)*64, (r*4+4)*64, 1'b1, st);
    @(negedge CLK);
    chk("flush_fresh_block", OUT_BLOCK, 128'h0102030405060708090a0b0c0d0e0f10);
    @(posedge CLK);
    #1;
    wait_drain();

    // Randomized traffic with random backpressure and ROUND_EN changing mid-block
    done = 0;
    fork
      begin
        for (int i = 0; i < 160; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge CLK);
            #1;
          end
          send_rand(1'($urandom_range(0, 1)), st);
        end
        done = 1;
      end
      begin
        while (!done) begin
          OUT_READY = 1'($urandom_range(0, 1));
          @(posedge CLK);
          #1;
        end
      end
    join
    wait_drain();

    // Async reset mid-block, no clock edge
    for (int r = 0; r < 6; r++) send_rand(1'b1, st);
    #2;
    RST_ASYNC_N = 1'b0;
    #1;
    chk("areset_out_valid", 128'(OUT_VALID), 128'(0));
    chk("areset_in_ready", 128'(IN_READY), 128'(1));
    chk("areset_block_cnt", 128'(BLOCK_CNT), 128'(0));
    exp_q.delete();
    part_q.delete();
    exp_cnt = 0;
    @(posedge CLK);
    #1;
    RST_ASYNC_N = 1'b1;
    for (int r = 0; r < 4; r++) send_rand(1'($urandom_range(0, 1)), st);
    wait_drain();

    @(negedge CLK);
    chk("final_block_cnt", 128'(BLOCK_CNT), 128'(1));
    chk("final_queue_empty", 128'(exp_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/interp_block_collector.md
Name: interp_block_collector

Overview:
- Downstream stage of the interpolation datapath. Consumes one row of four 14-bit signed interpolated samples per handshake (the four interpolator outputs).
- Rounds, shifts and clips each sample to 8-bit unsigned pixels, and assembles four rows into a 4x4 prediction block.
- Ping-pong double buffering (two 4x4 banks) lets the interpolator fill one block while the consumer (residual/SAD stage) drains the other.
- Output is a valid/ready interface with backpressure.

Parameters:
- SHIFT, 6, right-shift applied in rounding mode (1 to 13).
- IN_W, 14, width of each input sample.
- PIX_W, 8, width of each output pixel.

Ports:
- CLK  in  1  clock, rising edge.
- RST_ASYNC_N  in  1  asynchronous active-low reset.
- FLUSH  in  1  synchronous clear: drops any partial block and both banks.
- ROUND_EN  in  1  1 = round and shift by SHIFT; 0 = clip only. Sampled on row 0 of each block.
- IN_VALID  in  1  a row is presented on IN_SAMPLE_0..3.
- IN_READY  out  1  the collector accepts a row this cycle.
- IN_SAMPLE_0  in  14  leftmost sample of the row, signed.
- IN_SAMPLE_1  in  14  sample 1, signed.
- IN_SAMPLE_2  in  14  sample 2, signed.
- IN_SAMPLE_3  in  14  rightmost sample, signed.
- OUT_VALID  out  1  a complete 4x4 block is presented.
- OUT_READY  in  1  the consumer takes the block.
- OUT_BLOCK  out  128  16 pixels. Row 0 is in [127:96]. Within each row, sample 0 is in the MSB byte.
- BLOCK_CNT  out  8  count of blocks delivered; wraps modulo 256.

Behaviour:
- Reset (async, RST_ASYNC_N=0):
  - Both banks empty, pixel storage zero.
  - Row counter 0, fill pointer 0, read pointer 0.
  - OUT_VALID=0, OUT_BLOCK=0, BLOCK_CNT=0, IN_READY=1 once reset is released.
- Conversion is combinational, per sample x (signed 14-bit):
  - ROUND_EN=1: y = (x + 2^(SHIFT-1)) >>> SHIFT, with the add done at 15 bits so it cannot overflow.
  - ROUND_EN=0: y = x.
  - Clip: y<0 gives 0; y>255 gives 255; otherwise y[7:0].
- Input accept: a row is accepted on a rising edge when IN_VALID && IN_READY.
  - The converted row is written to row slot row_cnt of bank fill_ptr.
  - row_cnt increments.
  - The ROUND_EN value latched at row 0 applies to all four rows of that block.
- Block complete: the accept with row_cnt=3 sets full[fill_ptr]=1, toggles fill_ptr and sets row_cnt=0.
- IN_READY = !full[fill_ptr]. It is purely combinational from registered state, with no dependency on IN_VALID.
- Output:
  - OUT_VALID = full[rd_ptr]. OUT_BLOCK is bank rd_ptr, registered storage driven directly.
  - On OUT_VALID && OUT_READY: full[rd_ptr] clears, rd_ptr toggles, BLOCK_CNT increments (255 wraps to 0).
- Latency: OUT_VALID rises on the edge that accepts row 3 of the block, provided that bank was empty. The first pixel is visible 1 cycle after its row is accepted.
- Throughput: 1 row per cycle with OUT_READY held high. There is no bubble between consecutive blocks.
- Simultaneous events:
  - Completing a block in one bank while draining the other in the same cycle is legal. Both updates take effect.
  - Completing into a bank while that same bank is being drained is impossible, because IN_READY=0 while it is full.
- Both banks full: IN_READY=0. Rows are held off until the consumer takes a block.
- Input side holds IN_SAMPLE/IN_VALID stable until accepted (checked by assertion, not enforced).
- FLUSH=1 at a clock edge:
  - full[1:0]=0, row_cnt=0, fill_ptr=rd_ptr=0, OUT_VALID falls next cycle.
  - Any handshake in that cycle is ignored.
  - BLOCK_CNT is not cleared. Pixel storage is not cleared.
- Reset asserted mid-block: all state returns to reset values immediately; the partial block is discarded.

Decomposition:
- Shared package holds:
  - constants ROWS=4, COLS=4, PIX_MAX=255;
  - the bank index type (1 bit) and row index type (2 bits);
  - the OUT_BLOCK packing order function.
- Sub-module round_clip_pixel: combinational, parameterised by SHIFT, instantiated 4 times.
- The bank storage and pointer logic stay in the top module.

Test Plan:
- Single block, ROUND_EN=1, SHIFT=6: rows with samples 64, 95, 96, -32.
  - Pixels are 1, 1, 2, 0 (round half up; -32 rounds to 0).
  - OUT_VALID on the edge accepting row 3; BLOCK_CNT increments to 1 after the handshake.
- Clip paths, ROUND_EN=0: samples 300, -5, 255, 0 give 255, 0, 255, 0. Sample 8191 (max positive) gives 255.
- Backpressure:
  - OUT_READY=0 while feeding 12 rows. IN_READY drops after row 8 is accepted (both banks full).
  - Rows 9-12 are stalled.
  - Raising OUT_READY for one cycle delivers block 0, then accepts row 9 the next cycle.
- Streaming: 8 blocks back-to-back with OUT_READY=1.
  - One row accepted every cycle.
  - OUT_VALID pulses once per 4 cycles with blocks in order.
  - BLOCK_CNT=8.
- FLUSH after 2 rows of a block, with one full block pending:
  - OUT_VALID=0 next cycle.
  - The next 4 rows form a fresh block whose row 0 sits in [127:96].
- Async reset asserted mid-row-2 with no clock edge: OUT_VALID=0, IN_READY=1 and BLOCK_CNT=0 immediately.
